// File: rtl/hack_alu_sequencer.sv
// Execute-stage controller for the Hack CPU: decodes A/C instructions, drives an external ALU, retires results.
// Optional macro HACK_ALU_CHECK_EN builds a shadow ALU that raises a sticky alu_err on any result mismatch.
module hack_alu_sequencer #(
  parameter int                 WIDTH   = 16,
  parameter int                 ADDR_W  = 15,
  parameter logic [WIDTH-1:0]   RESET_A = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  instr,
  output logic              instr_ready,
  input  logic [WIDTH-1:0]  inM,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [WIDTH-1:0]  regA,
  output logic [WIDTH-1:0]  regD,
  output logic              done,
  output logic              jump,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              alu_err
);

  typedef enum logic {IDLE, EXEC} stateT;

  stateT             state;
  logic [12:0]       cReg;       // a-bit, comp[5:0], dest[2:0], jump[2:0] of the latched C-instruction
  logic [WIDTH-1:0]  aluXHold;
  logic [WIDTH-1:0]  aluYHold;
  logic [WIDTH-1:0]  yLive;
  logic              inExec;
  logic              accept;
  logic              takeJump;

  assign inExec      = (state == EXEC);
  assign instr_ready = (state == IDLE) & ~reset;
  assign accept      = instr_valid & instr_ready;

  assign yLive = cReg[12] ? inM : regA;
  assign alu_x = inExec ? regD  : aluXHold;
  assign alu_y = inExec ? yLive : aluYHold;

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = cReg[11:6];

  assign outM     = alu_out;
  assign writeM   = inExec & cReg[3] & ~reset;
  assign addressM = regA[ADDR_W-1:0];

  assign takeJump = (cReg[2] & alu_ng) | (cReg[1] & alu_zr) | (cReg[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      regA      <= RESET_A;
      regD      <= '0;
      cReg      <= '0;
      aluXHold  <= '0;
      aluYHold  <= '0;
      done      <= 1'b0;
      jump      <= 1'b0;
      jump_addr <= '0;
    end else begin
      done <= 1'b0;
      jump <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!instr[WIDTH-1]) begin
              regA <= instr;
              done <= 1'b1;
            end else begin
              cReg  <= instr[12:0];
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          // Jump target and M address use A as it was before this instruction writes it.
          if (cReg[5]) regA <= alu_out;
          if (cReg[4]) regD <= alu_out;
          aluXHold  <= regD;
          aluYHold  <= yLive;
          done      <= 1'b1;
          jump      <= takeJump;
          jump_addr <= regA[ADDR_W-1:0];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HACK_ALU_CHECK_EN
  logic [WIDTH-1:0] modelX;
  logic [WIDTH-1:0] modelY;
  logic [WIDTH-1:0] modelOut;
  logic             aluMismatch;
  logic             aluErr;

  always_comb begin
    modelX = cReg[11] ? '0 : alu_x;
    if (cReg[10]) modelX = ~modelX;
    modelY = cReg[9] ? '0 : alu_y;
    if (cReg[8]) modelY = ~modelY;
    modelOut = cReg[7] ? (modelX + modelY) : (modelX & modelY);
    if (cReg[6]) modelOut = ~modelOut;
    aluMismatch = (modelOut != alu_out) | (alu_zr != (modelOut == '0)) |
                  (alu_ng != modelOut[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset)                       aluErr <= 1'b0;
    else if (inExec && aluMismatch)  aluErr <= 1'b1;
  end

  assign alu_err = aluErr;
`else
  assign alu_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_alu_sequencer.sv
// Randomized self-checking bench for hack_alu_sequencer against a Hack-semantics reference model.
module tb_hack_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] inM;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [15:0] regA, regD;
  logic        done, jump;
  logic [14:0] jump_addr;
  logic        alu_err;

  int compared = 0;
  int mismatched = 0;

  logic        forceErr = 1'b0;
  logic [15:0] envMem [256];
  logic [15:0] modelMem [256];
  logic [15:0] modelA, modelD;

  hack_alu_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .inM(inM), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .outM(outM), .writeM(writeM), .addressM(addressM), .regA(regA), .regD(regD),
    .done(done), .jump(jump), .jump_addr(jump_addr), .alu_err(alu_err)
  );

  always #5 clk = ~clk;

  // Hack ALU written from its truth-table definition.
  function automatic logic [15:0] hackAlu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xs, ys, r;
    xs = c[5] ? 16'd0 : x;
    xs = c[4] ? ~xs : xs;
    ys = c[3] ? 16'd0 : y;
    ys = c[2] ? ~ys : ys;
    r  = c[1] ? xs + ys : xs & ys;
    return c[0] ? ~r : r;
  endfunction

  function automatic logic [15:0] memInit(input int i);
    return 16'(i * 16'h0123) ^ 16'hA5C3;
  endfunction

  always_comb begin
    alu_out = forceErr ? 16'h1234 : hackAlu({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_x, alu_y);
    alu_zr  = (alu_out == 16'd0);
    alu_ng  = alu_out[15];
  end

  assign inM = envMem[addressM[7:0]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) envMem[i] <= memInit(i);
    end else if (writeM) begin
      envMem[addressM[7:0]] <= outM;
    end
  end

  task automatic loadModel();
    for (int i = 0; i < 256; i++) modelMem[i] = memInit(i);
    modelA = 16'd0;
    modelD = 16'd0;
  endtask

  // Issue one instruction, check its EXEC cycle (C only) and its retirement against the model.
  task automatic send(input logic [15:0] w);
    logic [15:0] eY, eOut;
    logic        eJump;
    @(negedge clk);
    for (int k = 0; k < 8 && !instr_ready; k++) @(negedge clk);
    compared++;
    if (instr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_timeout: instr_ready=%b required 1 (instr %h)", instr_ready, w);
    end
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (!w[15]) begin
      modelA = w;
      compared++;
      if (done !== 1'b1 || jump !== 1'b0 || regA !== modelA || regD !== modelD || instr_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL a_instr %h: done=%b jump=%b regA=%h regD=%h ready=%b required 1 0 %h %h 1",
                 w, done, jump, regA, regD, instr_ready, modelA, modelD);
      end
    end else begin
      eY    = w[12] ? modelMem[modelA[7:0]] : modelA;
      eOut  = forceErr ? 16'h1234 : hackAlu(w[11:6], modelD, eY);
      eJump = (w[2] && $signed(eOut) < 0) || (w[1] && eOut == 16'd0) || (w[0] && $signed(eOut) > 0);
      compared++;
      if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== w[11:6] || alu_x !== modelD || alu_y !== eY ||
          writeM !== w[3] || outM !== eOut || addressM !== modelA[14:0] || done !== 1'b0 || instr_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL c_exec %h: ctl=%b x=%h y=%h wM=%b outM=%h addrM=%h done=%b rdy=%b required %b %h %h %b %h %h 0 0",
                 w, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_x, alu_y, writeM, outM, addressM,
                 done, instr_ready, w[11:6], modelD, eY, w[3], eOut, modelA[14:0]);
      end
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b1 || jump !== eJump || jump_addr !== modelA[14:0]) begin
        mismatched++;
        $display("FAIL c_retire %h: done=%b jump=%b jaddr=%h required 1 %b %h",
                 w, done, jump, jump_addr, eJump, modelA[14:0]);
      end
      if (w[3]) modelMem[modelA[7:0]] = eOut;
      if (w[5]) modelA = eOut;
      if (w[4]) modelD = eOut;
      compared++;
      if (regA !== modelA || regD !== modelD || instr_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL c_regs %h: regA=%h regD=%h ready=%b required %h %h 1", w, regA, regD, instr_ready, modelA, modelD);
      end
    end
    $display("txn %h: regA=%h regD=%h jump=%b", w, regA, regD, jump);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_in_reset: instr_ready=%b required 0", instr_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    loadModel();
    #1;
    compared++;
    if (instr_ready !== 1'b1 || regA !== 16'd0 || regD !== 16'd0 || done !== 1'b0 || jump !== 1'b0 ||
        writeM !== 1'b0 || alu_err !== 1'b0 || jump_addr !== 15'd0 ||
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_state: rdy=%b A=%h D=%h done=%b jump=%b wM=%b err=%b jaddr=%h ctl=%b",
               instr_ready, regA, regD, done, jump, writeM, alu_err, jump_addr,
               {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
  endtask

  task automatic test_directed();
    send(16'h0005);
    send(16'hEC10);
    compared++;
    if (regD !== 16'h0005) begin
      mismatched++;
      $display("FAIL d_eq_a: regD=%h required 0005", regD);
    end
    send(16'hE7C8);
    compared++;
    if (regD !== 16'h0005 || modelMem[5] !== 16'h0006) begin
      mismatched++;
      $display("FAIL m_eq_d1: regD=%h required 0005", regD);
    end
    send(16'h0010);
    send(16'hEA87);
    compared++;
    if (jump !== 1'b1 || jump_addr !== 15'h0010) begin
      mismatched++;
      $display("FAIL jmp: jump=%b jaddr=%h required 1 0010", jump, jump_addr);
    end
    send(16'h7FFF);
    send(16'hEC10);
    send(16'hE7D0);
    send(16'hE304);
    compared++;
    if (regD !== 16'h8000 || jump !== 1'b1) begin
      mismatched++;
      $display("FAIL jlt: regD=%h jump=%b required 8000 1", regD, jump);
    end
    send(16'hE3A8);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) w = {1'b0, 15'($urandom)};
      else w = {3'b111, 13'($urandom)};
      send(w);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    instr = 16'hEFF8;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    compared++;
    if (writeM !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_writeM: writeM=%b required 0", writeM);
    end
    @(posedge clk);
    #1;
    compared++;
    if (regA !== 16'd0 || regD !== 16'd0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_regs: regA=%h regD=%h done=%b required 0000 0000 0", regA, regD, done);
    end
    @(negedge clk);
    reset = 1'b0;
    loadModel();
    @(posedge clk);
    #1;
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_done: done=%b required 0", done);
    end
    $display("txn abort: regA=%h regD=%h", regA, regD);
  endtask

  task automatic test_no_skid();
    send(16'h0042);
    @(negedge clk);
    instr = 16'hEC10;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 16'h0077;
    compared++;
    if (instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL exec_ready: instr_ready=%b required 0", instr_ready);
    end
    @(posedge clk);
    #1;
    modelD = modelA;
    compared++;
    if (done !== 1'b1 || regA !== modelA || regD !== modelD || instr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL no_skid_retire: done=%b regA=%h regD=%h rdy=%b required 1 %h %h 1",
               done, regA, regD, instr_ready, modelA, modelD);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    modelA = 16'h0077;
    compared++;
    if (done !== 1'b1 || regA !== 16'h0077) begin
      mismatched++;
      $display("FAIL held_accept: done=%b regA=%h required 1 0077", done, regA);
    end
    $display("txn no_skid: regA=%h regD=%h", regA, regD);
  endtask

  task automatic test_alu_check();
    logic expErr;
`ifdef HACK_ALU_CHECK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    send(16'hEC10);
    compared++;
    if (alu_err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_clean: alu_err=%b required 0", alu_err);
    end
    forceErr = 1'b1;
    send(16'hE7D0);
    forceErr = 1'b0;
    compared++;
    if (alu_err !== expErr) begin
      mismatched++;
      $display("FAIL err_set: alu_err=%b required %b", alu_err, expErr);
    end
    send(16'h0003);
    send(16'hE7D0);
    compared++;
    if (alu_err !== expErr) begin
      mismatched++;
      $display("FAIL err_sticky: alu_err=%b required %b", alu_err, expErr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    loadModel();
    compared++;
    if (alu_err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_reset: alu_err=%b required 0", alu_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_no_skid();
    test_random();
    test_alu_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
